// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for a shared NUMBER_INPUT:1 mux with a per-requester burst limit.
// The selected word is captured into a one-entry output register with a valid/ready handshake.
module mux_rr_scheduler #(
    parameter  int BIT          = 19,
    parameter  int NUMBER_INPUT = 8,
    parameter  int BURST        = 2,
    localparam int SEL_W        = $clog2(NUMBER_INPUT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUMBER_INPUT-1:0]     req,
    input  logic [NUMBER_INPUT*BIT-1:0] IN,
    output logic [NUMBER_INPUT-1:0]     gnt,
    output logic [SEL_W-1:0]            sel,
    output logic [BIT-1:0]              out,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int                     CNT_W   = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0]       BURST_C = CNT_W'(BURST);
    localparam logic [SEL_W-1:0]       LAST_IX = SEL_W'(NUMBER_INPUT - 1);

    logic [SEL_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [BIT-1:0]   out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             load;
    logic             locked;
    logic             grant;
    logic             found;
    logic [SEL_W-1:0] scan_ix;
    logic [SEL_W-1:0] search_w;
    logic [SEL_W-1:0] win;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred; blocking '=' here.
        load        = ~out_valid_q | out_ready;
        locked      = (cnt_q != '0) && (cnt_q < BURST_C) && req[owner_q];
        grant       = load && (|req) && !rst;
        found       = 1'b0;
        scan_ix     = owner_q;
        search_w    = owner_q;
        gnt         = '0;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        // Scan owner+1 .. owner (wrapping last); explicit compare keeps non-power-of-2 counts in range.
        for (int k = 0; k < NUMBER_INPUT; k++) begin
            scan_ix = (scan_ix == LAST_IX) ? '0 : scan_ix + 1'b1;
            if (!found && req[scan_ix]) begin
                found    = 1'b1;
                search_w = scan_ix;
            end
        end

        win = locked ? owner_q : search_w;

        if (grant) begin
            gnt[win]    = 1'b1;
            sel_d       = win;
            owner_d     = win;
            out_valid_d = 1'b1;
            cnt_d       = locked ? cnt_q + CNT_W'(1) : CNT_W'(1);
            // Only the winning slot is read, so X on unrequested slots never reaches out.
            for (int i = 0; i < NUMBER_INPUT; i++) begin
                if (win == SEL_W'(i)) out_d = IN[i*BIT +: BIT];
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so all flops update together.
        if (rst) begin
            owner_q     <= LAST_IX;
            cnt_q       <= '0;
            sel_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: two instances (BURST=2 and BURST=4) share stimulus and are
// compared each cycle against a behavioural round-robin model, plus directed sequence checks.
module tb_mux_rr_scheduler;

    localparam int N  = 8;
    localparam int W  = 19;
    localparam int SW = $clog2(N);

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] in_bus;
    logic           out_ready;

    logic [N-1:0]   gnt_o [2];
    logic [SW-1:0]  sel_o [2];
    logic [W-1:0]   out_o [2];
    logic           vld_o [2];

    int checks = 0;
    int errors = 0;

    logic [W-1:0] in_w [N];
    int           bursts   [2] = '{2, 4};
    int           m_owner  [2];
    int           m_cnt    [2];
    int           m_sel    [2];
    logic         m_valid  [2];
    logic [W-1:0] m_out    [2];
    int           last_win [2];

    mux_rr_scheduler #(.BIT(W), .NUMBER_INPUT(N), .BURST(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req), .IN(in_bus),
        .gnt(gnt_o[0]), .sel(sel_o[0]), .out(out_o[0]),
        .out_valid(vld_o[0]), .out_ready(out_ready)
    );

    mux_rr_scheduler #(.BIT(W), .NUMBER_INPUT(N), .BURST(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .IN(in_bus),
        .gnt(gnt_o[1]), .sel(sel_o[1]), .out(out_o[1]),
        .out_valid(vld_o[1]), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requested slots get fresh random words; unrequested slots are driven X.
    task automatic set_req(input logic [N-1:0] r);
        req = r;
        for (int i = 0; i < N; i++) begin
            in_w[i] = r[i] ? W'($urandom) : 'x;
            in_bus[i*W +: W] = in_w[i];
        end
    endtask

    function automatic bit m_locked(int d);
        return m_cnt[d] >= 1 && m_cnt[d] < bursts[d] && req[m_owner[d]];
    endfunction

    function automatic int m_winner(int d);
        if (rst || !(!m_valid[d] || out_ready) || req == '0) return -1;
        if (m_locked(d)) return m_owner[d];
        for (int k = 1; k <= N; k++) begin
            if (req[(m_owner[d] + k) % N]) return (m_owner[d] + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = N - 1;
            m_cnt[d]   = 0;
            m_sel[d]   = 0;
            m_valid[d] = 1'b0;
            m_out[d]   = '0;
        end
    endtask

    // Inputs are set just after a falling edge; gnt is checked before the rising edge,
    // registered outputs at the following falling edge.
    task automatic cycle();
        int  w  [2];
        bit  lk [2];
        logic [N-1:0] eg;
        #1;
        for (int d = 0; d < 2; d++) begin
            w[d]  = m_winner(d);
            lk[d] = m_locked(d);
            eg    = '0;
            if (w[d] >= 0) eg[w[d]] = 1'b1;
            check($sformatf("gnt[b%0d]", bursts[d]), 32'(gnt_o[d]), 32'(eg));
            last_win[d] = w[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_owner[d] = N - 1;
                m_cnt[d]   = 0;
                m_sel[d]   = 0;
                m_valid[d] = 1'b0;
                m_out[d]   = '0;
            end else if (w[d] >= 0) begin
                m_cnt[d]   = (lk[d] && w[d] == m_owner[d]) ? m_cnt[d] + 1 : 1;
                m_owner[d] = w[d];
                m_sel[d]   = w[d];
                m_out[d]   = in_w[w[d]];
                m_valid[d] = 1'b1;
            end else if (out_ready) begin
                m_valid[d] = 1'b0;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("out_valid[b%0d]", bursts[d]), 32'(vld_o[d]), 32'(m_valid[d]));
            check($sformatf("sel[b%0d]", bursts[d]), 32'(sel_o[d]), 32'(m_sel[d]));
            check($sformatf("out[b%0d]", bursts[d]), 32'(out_o[d]), 32'(m_out[d]));
        end
    endtask

    initial begin
        logic [W-1:0] held_out;
        logic [N-1:0] r;
        int           mode;

        rst       = 1'b1;
        out_ready = 1'b1;
        set_req(8'hFF);
        model_reset();
        @(negedge clk);

        // Reset held for 3 cycles with every requester active.
        for (int c = 0; c < 3; c++) cycle();
        check("reset_valid", 32'(vld_o[0]), 32'd0);
        check("reset_sel", 32'(sel_o[0]), 32'd0);

        // Full contention: grant sequence 0,0,1,1,...,7,7,0,0 with BURST=2.
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_req(8'hFF);
            cycle();
            check("contention_seq", 32'(last_win[0]), 32'((k / 2) % N));
        end

        // Sole requester keeps winning; sel pinned at 5.
        for (int k = 0; k < 6; k++) begin
            set_req(8'h20);
            cycle();
            check("sole_gnt", 32'(gnt_o[0]), 32'h20);
        end
        check("sole_sel", 32'(sel_o[0]), 32'd5);
        check("sole_valid", 32'(vld_o[0]), 32'd1);

        // Backpressure: nothing moves for 4 cycles, then release grants immediately.
        held_out  = out_o[0];
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(8'hFF);
            cycle();
        end
        check("bp_hold_out", 32'(out_o[0]), 32'(held_out));
        out_ready = 1'b1;
        set_req(8'hFF);
        cycle();
        check("bp_release_grant", 32'(last_win[0] >= 0), 32'd1);

        // Owner drop mid-burst on the BURST=4 instance.
        rst = 1'b1;
        set_req(8'h48);
        cycle();
        rst = 1'b0;
        set_req(8'h48);
        cycle();
        check("drop_first", 32'(last_win[1]), 32'd3);
        set_req(8'h40);
        cycle();
        check("drop_switch", 32'(last_win[1]), 32'd6);
        for (int k = 0; k < 3; k++) begin
            set_req(8'h48);
            cycle();
            check("drop_burst", 32'(last_win[1]), 32'd6);
        end
        set_req(8'h48);
        cycle();
        check("drop_back", 32'(last_win[1]), 32'd3);

        // Mid-operation reset while requester 2 holds the output register.
        set_req(8'h04);
        cycle();
        check("midrst_pre_valid", 32'(vld_o[0]), 32'd1);
        rst = 1'b1;
        set_req(8'h04);
        cycle();
        check("midrst_valid", 32'(vld_o[0]), 32'd0);
        check("midrst_sel", 32'(sel_o[0]), 32'd0);
        rst = 1'b0;
        set_req(8'h0C);
        cycle();
        check("midrst_first", 32'(last_win[0]), 32'd2);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       r = N'($urandom);
                1:       r = N'(1) << $urandom_range(0, N - 1);
                2:       r = '0;
                default: r = '1;
            endcase
            rst       = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_req(r);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler that shares the NUMBER_INPUT:1 BIT-wide mux datapath between NUMBER_INPUT requesters. Each cycle it picks one requesting input, drives the mux select, and captures the selected word into a one-entry output register with a valid/ready handshake. It sits between the requester front-ends and the single downstream consumer of the mux output. A per-requester burst limit bounds how long one requester may hold the mux.

## Interface
- BIT, 19, data width of each input word and of the output
- NUMBER_INPUT, 8, number of requesters / mux inputs (≥2, need not be a power of 2)
- BURST, 2, max consecutive grants to one requester while others wait (≥1)
- SEL_W (localparam), $clog2(NUMBER_INPUT), select width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUMBER_INPUT  req[i]=1: requester i presents a valid word
- IN  in  NUMBER_INPUT*BIT  packed words; requester i at IN[i*BIT +: BIT]
- gnt  out  NUMBER_INPUT  one-hot (or zero), combinational; gnt[i]=1 means word i is captured at this rising edge
- sel  out  SEL_W  registered index of the most recent grant; drives the shared mux select
- out  out  BIT  registered selected word
- out_valid  out  1  out holds an unconsumed word
- out_ready  in  1  consumer accepts out when out_valid&out_ready

## Operation
- load = ~out_valid | out_ready. Grant only when load=1 and |req=1; otherwise gnt=0.
- State: owner (SEL_W bits, last granted index), cnt (burst count, 0..BURST).
- Winner selection when load:
  - LOCKED: cnt≥1, cnt<BURST and req[owner]=1 → winner=owner.
  - Otherwise SEARCH: first i with req[i]=1 scanning owner+1, owner+2, … mod NUMBER_INPUT, wrapping to owner last. Owner therefore wins again only if it is the sole requester.
- On grant to winner w: gnt[w]=1; out<=IN[w*BIT +: BIT]; sel<=w; out_valid<=1; cnt<=(w==owner && LOCKED) ? cnt+1 : 1; owner<=w.
- Sole-requester re-win after cnt==BURST restarts cnt at 1.
- If owner drops req mid-burst, next grant is via SEARCH (cnt restarts at 1 for new winner).
- No grant and out_ready=1: out_valid<=0; out, sel, owner, cnt hold.
- out_valid=1 and out_ready=0: gnt=0; out, sel, out_valid, owner, cnt hold.
- Modulo wrap uses explicit compare against NUMBER_INPUT-1 (non-power-of-2 safe); sel never exceeds NUMBER_INPUT-1.
- IN/req values when req[i]=0 are don't-care (may be X); no X may propagate to gnt/out from unrequested slots.

## Timing
- Reset (rst=1 at edge): out_valid=0, out=0, sel=0, owner=NUMBER_INPUT-1, cnt=0; gnt=0 while rst=1 regardless of req. First grant after reset goes to lowest-indexed requester.
- Reset mid-operation discards any held output word; no grant issued in reset cycles.
- Latency: word granted at edge k appears on out with out_valid=1 after edge k (1 cycle).
- Throughput: one word per cycle when out_ready=1 continuously (pass-through load on same cycle as consume).
- gnt is a same-cycle combinational function of req, out_valid, out_ready, owner, cnt; requester advances its word on edge where gnt[i]=1.
- Fairness: with all requesters active, any requester waits at most (NUMBER_INPUT-1)*BURST grants.

## Test plan
- Reset: rst=1 for 3 cycles with req=8'hFF, out_ready=1 → gnt=0, out_valid=0, sel=0 every cycle; first grant after release is gnt=8'h01, then out=IN[18:0], sel=0 next cycle.
- Full contention, BURST=2, req=8'hFF, out_ready=1 → grant index sequence 0,0,1,1,…,7,7,0,0; each out equals granted slice one cycle later; sel tracks index.
- Sole requester: req=8'h20, BURST=2 → gnt=8'h20 every cycle, out_valid stays 1, sel=5 continuously.
- Backpressure: out_valid=1, out_ready=0 for 4 cycles with req=8'hFF → gnt=0, out/sel unchanged; cycle out_ready rises, next grant fires same cycle and out updates next edge.
- Owner drop mid-burst, BURST=4, req=8'h48: 3 granted once, then req[3]=0 → next grant 6, cnt=1; 6 then holds 4 grants before 3 (re-asserted) wins.
- Mid-operation reset during burst on requester 2 with out_valid=1 → after rst edge out_valid=0, sel=0; after release with req=8'h0C first grant is 2.
